// File: rtl/frame_buf_sched.sv
// Triple-buffer slot scheduler for the camera->DDR->HDMI frame store.
// Ports: clk/rst_n, enable, wr_start/wr_done/rd_start pulses in;
//   wr_active, wr/rd slot index + base address, rd_valid,
//   drop_cnt and repeat_cnt statistics out (all registered).
module frame_buf_sched #(
  parameter logic [31:0] BASE_ADDR   = 32'h0100_0000,
  parameter logic [31:0] FRAME_BYTES = 32'h0009_6000,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             wr_start,
  input  logic             wr_done,
  input  logic             rd_start,
  output logic             wr_active,
  output logic [1:0]       wr_buf_idx,
  output logic [31:0]      wr_base_addr,
  output logic [1:0]       rd_buf_idx,
  output logic [31:0]      rd_base_addr,
  output logic             rd_valid,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] repeat_cnt
);

  typedef enum logic {W_IDLE, W_ACTIVE} wst_t;

  localparam logic [31:0] ADDR1 = BASE_ADDR + FRAME_BYTES;
  localparam logic [31:0] ADDR2 = BASE_ADDR + (FRAME_BYTES << 1);

  wst_t st_q, st_d;
  logic [1:0] w_q, r_q, l_q;
  logic [1:0] w_d, r_d, l_d;
  logic fresh_q, fresh_d;
  logic have_q, have_d;
  logic rv_q, rv_d;
  logic drop_inc, rep_inc;
  logic [CNT_W-1:0] drop_q, rep_q;
  logic [31:0] wa_q, ra_q;

  function automatic logic [31:0] slot_addr(input logic [1:0] i);
    logic [31:0] a;
    unique case (i)
      2'd1:    a = ADDR1;
      2'd2:    a = ADDR2;
      default: a = BASE_ADDR;
    endcase
    return a;
  endfunction

  // Order within a cycle: commit, then read swap, then new start.
  always_comb begin
    st_d     = st_q;
    w_d      = w_q;
    r_d      = r_q;
    l_d      = l_q;
    fresh_d  = fresh_q;
    have_d   = have_q;
    rv_d     = rv_q;
    drop_inc = 1'b0;
    rep_inc  = 1'b0;
    unique case (st_q)
      W_IDLE: begin
        if (wr_start && enable) st_d = W_ACTIVE;
      end
      W_ACTIVE: begin
        if (wr_done) begin
          w_d      = l_q;
          l_d      = w_q;
          drop_inc = fresh_q;
          fresh_d  = 1'b1;
          have_d   = 1'b1;
          st_d     = (wr_start && enable) ? W_ACTIVE : W_IDLE;
        end else if (wr_start) begin
          drop_inc = 1'b1;
          st_d     = enable ? W_ACTIVE : W_IDLE;
        end
      end
    endcase
    if (rd_start) begin
      if (fresh_d) begin
        r_d     = l_d;
        l_d     = r_q;
        fresh_d = 1'b0;
        rv_d    = 1'b1;
      end else if (have_q) begin
        rep_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q    <= W_IDLE;
      w_q     <= 2'd0;
      r_q     <= 2'd1;
      l_q     <= 2'd2;
      fresh_q <= 1'b0;
      have_q  <= 1'b0;
      rv_q    <= 1'b0;
      drop_q  <= '0;
      rep_q   <= '0;
      wa_q    <= BASE_ADDR;
      ra_q    <= ADDR1;
    end else begin
      st_q    <= st_d;
      w_q     <= w_d;
      r_q     <= r_d;
      l_q     <= l_d;
      fresh_q <= fresh_d;
      have_q  <= have_d;
      rv_q    <= rv_d;
      wa_q    <= slot_addr(w_d);
      ra_q    <= slot_addr(r_d);
      if (drop_inc && drop_q != '1) drop_q <= drop_q + 1'b1;
      if (rep_inc && rep_q != '1) rep_q <= rep_q + 1'b1;
    end
  end

  assign wr_active    = (st_q == W_ACTIVE);
  assign wr_buf_idx   = w_q;
  assign rd_buf_idx   = r_q;
  assign wr_base_addr = wa_q;
  assign rd_base_addr = ra_q;
  assign rd_valid     = rv_q;
  assign drop_cnt     = drop_q;
  assign repeat_cnt   = rep_q;

endmodule

// File: tb/tb_frame_buf_sched.sv
// Directed vector bench for frame_buf_sched.
// Table rows plus hand sequences for reset, addresses, saturation.
module tb_frame_buf_sched;

  logic clk = 1'b0;
  logic rst_n, enable, wr_start, wr_done, rd_start;
  logic wr_active, rd_valid;
  logic [1:0] wr_buf_idx, rd_buf_idx;
  logic [31:0] wr_base_addr, rd_base_addr;
  logic [15:0] drop_cnt, repeat_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  frame_buf_sched dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .wr_start(wr_start), .wr_done(wr_done), .rd_start(rd_start),
    .wr_active(wr_active), .wr_buf_idx(wr_buf_idx),
    .wr_base_addr(wr_base_addr), .rd_buf_idx(rd_buf_idx),
    .rd_base_addr(rd_base_addr), .rd_valid(rd_valid),
    .drop_cnt(drop_cnt), .repeat_cnt(repeat_cnt)
  );

  typedef struct packed {
    logic rn, en, ws, wd, rs;
    logic wa;
    logic [1:0] wi, ri;
    logic rv;
    logic [15:0] dc, rc;
  } vec_t;

  vec_t vq[$];

  function automatic void add(
    input logic rn, en, ws, wd, rs, wa,
    input logic [1:0] wi, ri,
    input logic rv, input logic [15:0] dc, rc);
    vec_t v;
    v = '{rn, en, ws, wd, rs, wa, wi, ri, rv, dc, rc};
    vq.push_back(v);
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act, exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic step(input logic rn, en, ws, wd, rs);
    @(negedge clk);
    rst_n = rn; enable = en;
    wr_start = ws; wr_done = wd; rd_start = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_wa"}, 32'(wr_active), 0);
    chk({tag, "_wi"}, 32'(wr_buf_idx), 0);
    chk({tag, "_ri"}, 32'(rd_buf_idx), 1);
    chk({tag, "_rv"}, 32'(rd_valid), 0);
    chk({tag, "_dc"}, 32'(drop_cnt), 0);
    chk({tag, "_rc"}, 32'(repeat_cnt), 0);
    chk({tag, "_wba"}, wr_base_addr, 32'h0100_0000);
    chk({tag, "_rba"}, rd_base_addr, 32'h0109_6000);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0;
    wr_start = 1'b0; wr_done = 1'b0; rd_start = 1'b0;

    //  rn en ws wd rs | wa wi ri rv  drop rep
    add(0, 1, 0, 0, 0,  0, 0, 1, 0,  0, 0);
    add(0, 1, 1, 0, 1,  0, 0, 1, 0,  0, 0);
    add(1, 1, 0, 0, 1,  0, 0, 1, 0,  0, 0);
    add(1, 1, 1, 0, 0,  1, 0, 1, 0,  0, 0);
    add(1, 1, 0, 0, 0,  1, 0, 1, 0,  0, 0);
    add(1, 1, 0, 1, 0,  0, 2, 1, 0,  0, 0);
    add(1, 1, 0, 0, 1,  0, 2, 0, 1,  0, 0);
    add(1, 1, 0, 0, 1,  0, 2, 0, 1,  0, 1);
    add(1, 1, 0, 0, 1,  0, 2, 0, 1,  0, 2);
    add(1, 1, 0, 0, 1,  0, 2, 0, 1,  0, 3);
    add(1, 1, 1, 0, 0,  1, 2, 0, 1,  0, 3);
    add(1, 1, 0, 1, 0,  0, 1, 0, 1,  0, 3);
    add(1, 1, 1, 0, 0,  1, 1, 0, 1,  0, 3);
    add(1, 1, 0, 1, 0,  0, 2, 0, 1,  1, 3);
    add(1, 1, 0, 0, 1,  0, 2, 1, 1,  1, 3);
    add(1, 1, 1, 0, 0,  1, 2, 1, 1,  1, 3);
    add(1, 1, 0, 1, 0,  0, 0, 1, 1,  1, 3);
    add(1, 1, 1, 0, 0,  1, 0, 1, 1,  1, 3);
    add(1, 1, 0, 1, 1,  0, 2, 0, 1,  2, 3);
    add(1, 1, 1, 0, 0,  1, 2, 0, 1,  2, 3);
    add(1, 1, 1, 1, 0,  1, 1, 0, 1,  2, 3);
    add(1, 1, 1, 0, 0,  1, 1, 0, 1,  3, 3);
    add(1, 0, 0, 1, 0,  0, 2, 0, 1,  4, 3);
    add(1, 0, 1, 0, 0,  0, 2, 0, 1,  4, 3);
    add(1, 0, 0, 0, 1,  0, 2, 1, 1,  4, 3);
    add(1, 1, 1, 0, 0,  1, 2, 1, 1,  4, 3);
    add(1, 0, 1, 0, 0,  0, 2, 1, 1,  5, 3);
    add(1, 1, 0, 0, 0,  0, 2, 1, 1,  5, 3);
    add(1, 1, 0, 1, 0,  0, 2, 1, 1,  5, 3);

    foreach (vq[i]) begin
      vec_t v;
      string t;
      v = vq[i];
      t = $sformatf("row%0d", i);
      step(v.rn, v.en, v.ws, v.wd, v.rs);
      chk({t, "_wa"}, 32'(wr_active), 32'(v.wa));
      chk({t, "_wi"}, 32'(wr_buf_idx), 32'(v.wi));
      chk({t, "_ri"}, 32'(rd_buf_idx), 32'(v.ri));
      chk({t, "_rv"}, 32'(rd_valid), 32'(v.rv));
      chk({t, "_dc"}, 32'(drop_cnt), 32'(v.dc));
      chk({t, "_rc"}, 32'(repeat_cnt), 32'(v.rc));
    end

    // Slots now W=2, R=1.
    chk("addr_w2", wr_base_addr, 32'h0112_C000);
    chk("addr_r1", rd_base_addr, 32'h0109_6000);

    // Reset while a frame is in progress, with pulses held.
    step(1, 1, 1, 0, 0);
    chk("pre_rst_wa", 32'(wr_active), 1);
    step(0, 1, 1, 1, 1);
    chk_reset("midrst");
    step(1, 1, 0, 0, 0);
    chk_reset("postrst");

    // Single frame from reset then display.
    step(1, 1, 1, 0, 0);
    repeat (10) step(1, 1, 0, 0, 0);
    chk("t1_active", 32'(wr_active), 1);
    chk("t1_wba0", wr_base_addr, 32'h0100_0000);
    step(1, 1, 0, 1, 0);
    chk("t1_idle", 32'(wr_active), 0);
    chk("t1_wi", 32'(wr_buf_idx), 2);
    chk("t1_rv0", 32'(rd_valid), 0);
    step(1, 1, 0, 0, 1);
    chk("t1_ri", 32'(rd_buf_idx), 0);
    chk("t1_rv", 32'(rd_valid), 1);
    chk("t1_rba", rd_base_addr, 32'h0100_0000);
    chk("t1_wba", wr_base_addr, 32'h0112_C000);

    // Saturation: hold wr_start so every cycle aborts.
    step(1, 1, 1, 0, 0);
    repeat (70000) step(1, 1, 1, 0, 0);
    chk("sat_dc", 32'(drop_cnt), 32'h0000_FFFF);
    chk("sat_wa", 32'(wr_active), 1);
    chk("sat_wi", 32'(wr_buf_idx), 2);
    step(1, 1, 1, 0, 0);
    chk("sat_hold", 32'(drop_cnt), 32'h0000_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
